// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the mem_responder block: FSM state encoding,
// port-select constants, counter width and a small address helper.
// Optional feature macro used by the importing files: MEM_RESP_FAIRNESS_EN.
// -----------------------------------------------------------------------------
package mem_resp_pkg;

  // FSM state encoding: IDLE = 0, BUSY = 1, DONE = 2.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Port-select encoding used for the granted port and last_grant.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_ME = 1'b1;

  // Wait-cycle counter width; covers LATENCY up to 15.
  localparam int CNT_W = 4;

  // A byte address is misaligned when it does not point at a word boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage : mem_resp_pkg

// File: rtl/mem_resp_arbiter.sv
// -----------------------------------------------------------------------------
// mem_resp_arbiter
// Combinational grant logic for the two requesters of mem_responder.
//   IDLE : grant a pending request; on a tie, me wins (default build) or the
//          port not served last wins (MEM_RESP_FAIRNESS_EN build).
//   DONE : hand over directly to the other port if it is requesting; the
//          port just served is never re-granted here.
//   BUSY : no grant.
// Ports:
//   if_req_i       fetch request
//   me_req_i       data request
//   state_i        current responder FSM state
//   served_port_i  port owning the current/just-finished access
//   last_grant_i   port granted most recently (MEM_RESP_FAIRNESS_EN only)
//   grant_valid_o  a grant is issued this cycle
//   grant_port_o   which port is granted (PORT_IF / PORT_ME)
// Configuration macro: MEM_RESP_FAIRNESS_EN.
// -----------------------------------------------------------------------------
module mem_resp_arbiter
  import mem_resp_pkg::*;
(
  input  logic       if_req_i,
  input  logic       me_req_i,
  input  logic [1:0] state_i,
  input  logic       served_port_i,
`ifdef MEM_RESP_FAIRNESS_EN
  input  logic       last_grant_i,
`endif
  output logic       grant_valid_o,
  output logic       grant_port_o
);

  logic other_req;

  // Request line of the port that did not own the last access.
  assign other_req = (served_port_i == PORT_ME) ? if_req_i : me_req_i;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    grant_valid_o = 1'b0;
    grant_port_o  = PORT_ME;

    case (state_i)
      IDLE: begin
        if (me_req_i && if_req_i) begin
          grant_valid_o = 1'b1;
`ifdef MEM_RESP_FAIRNESS_EN
          grant_port_o  = (last_grant_i == PORT_IF) ? PORT_ME : PORT_IF;
`else
          grant_port_o  = PORT_ME;
`endif
        end else if (me_req_i) begin
          grant_valid_o = 1'b1;
          grant_port_o  = PORT_ME;
        end else if (if_req_i) begin
          grant_valid_o = 1'b1;
          grant_port_o  = PORT_IF;
        end
      end

      DONE: begin
        if (other_req) begin
          grant_valid_o = 1'b1;
          grant_port_o  = ~served_port_i;
        end
      end

      default: begin
        grant_valid_o = 1'b0;
      end
    endcase
  end

endmodule : mem_resp_arbiter

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the 5-stage pipeline. Serves the instruction
// fetch port and the MEM-stage data port from one single-ported 32-bit word
// RAM, with LATENCY wait cycles per access and an IDLE/BUSY/DONE FSM.
// Parameters:
//   ADDR_W   word-index width (RAM holds 2^ADDR_W words)
//   LATENCY  wait cycles per access, 1..15
// Ports:
//   clock, resetn        clock / asynchronous active-low reset
//   if_req, if_addr      fetch request and byte address
//   if_rdata, if_ready   fetched word and one-cycle completion pulse
//   me_req, me_we        data request, 1 = store / 0 = load
//   me_addr, me_wdata    data byte address and store data
//   me_rdata, me_ready   load data and one-cycle completion pulse
//   stall                pipeline freeze: some request still outstanding
//   misalign             sticky: an access had addr[1:0] != 0
// Configuration macro: MEM_RESP_FAIRNESS_EN (round-robin tie-break in IDLE).
// -----------------------------------------------------------------------------
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        me_req,
  input  logic        me_we,
  input  logic [31:0] me_addr,
  input  logic [31:0] me_wdata,
  output logic [31:0] me_rdata,
  output logic        me_ready,
  output logic        stall,
  output logic        misalign
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         me_rdata_q, me_rdata_d;
  logic                misalign_q, misalign_d;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         ram_word;
  logic                access_now;
  logic                ram_we;

  logic                grant_valid;
  logic                grant_port;
  logic [31:0]         sel_addr;

  // Upper address bits only alias; they are deliberately dropped.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], me_addr[31:ADDR_W+2]};

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef MEM_RESP_FAIRNESS_EN
  logic last_grant_q, last_grant_d;

  assign last_grant_d = grant_valid ? grant_port : last_grant_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= PORT_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  mem_resp_arbiter u_arbiter (
    .if_req_i      (if_req),
    .me_req_i      (me_req),
    .state_i       (state_q),
    .served_port_i (port_q),
`ifdef MEM_RESP_FAIRNESS_EN
    .last_grant_i  (last_grant_q),
`endif
    .grant_valid_o (grant_valid),
    .grant_port_o  (grant_port)
  );

  assign sel_addr = (grant_port == PORT_ME) ? me_addr : if_addr;

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  // The access happens on the edge that leaves BUSY with the counter at zero.
  assign access_now = (state_q == BUSY) && (cnt_q == '0);
  // we_q is only ever set for data-port grants, so fetches cannot write.
  assign ram_we     = access_now && we_q;
  assign ram_word   = mem[idx_q];

  // NOTE: the RAM array has no reset; its contents survive resetn and only
  // the control/state registers are cleared.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    port_d     = port_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    me_rdata_d = me_rdata_q;
    misalign_d = misalign_q;

    unique case (state_q)
      // IDLE and DONE both accept a grant; DONE falls back to IDLE otherwise.
      IDLE, DONE: begin
        if (grant_valid) begin
          state_d    = BUSY;
          cnt_d      = CNT_W'(LATENCY - 1);
          port_d     = grant_port;
          we_d       = (grant_port == PORT_ME) && me_we;
          idx_d      = sel_addr[ADDR_W+1:2];
          wdata_d    = me_wdata;
          misalign_d = misalign_q | is_misaligned(sel_addr);
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
          if (!we_q) begin
            if (port_q == PORT_ME) begin
              me_rdata_d = ram_word;
            end else begin
              if_rdata_d = ram_word;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      me_rdata_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      port_q     <= port_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      me_rdata_q <= me_rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign if_ready = (state_q == DONE) && (port_q == PORT_IF);
  assign me_ready = (state_q == DONE) && (port_q == PORT_ME);
  assign stall    = (if_req & ~if_ready) | (me_req & ~me_ready);
  assign if_rdata = if_rdata_q;
  assign me_rdata = me_rdata_q;
  assign misalign = misalign_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder (default build, ADDR_W=10, LATENCY=2).
// A table of single transactions is applied from IDLE, followed by hand-written
// multi-cycle sequences: simultaneous requests, continuous contention, a
// dropped request, and reset during an access.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;

  logic        clock = 1'b0;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        me_req;
  logic        me_we;
  logic [31:0] me_addr;
  logic [31:0] me_wdata;
  logic [31:0] me_rdata;
  logic        me_ready;
  logic        stall;
  logic        misalign;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  mem_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .me_req   (me_req),
    .me_we    (me_we),
    .me_addr  (me_addr),
    .me_wdata (me_wdata),
    .me_rdata (me_rdata),
    .me_ready (me_ready),
    .stall    (stall),
    .misalign (misalign)
  );

  typedef struct {
    logic        port;       // 1 = me, 0 = if
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;  // that port's rdata in the ready cycle
    logic        exp_mis;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Issue one request from IDLE (called at a drive point, request goes high
  // in cycle 0). Request fields are scrambled after the grant. Returns the
  // cycle of the ready pulse (-1 on timeout) and the port's rdata then.
  task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [31:0] rd);
    me_we    = we;
    me_wdata = wdata;
    if (port) begin
      me_req  = 1'b1;
      me_addr = addr;
    end else begin
      if_req  = 1'b1;
      if_addr = addr;
    end
    lat = -1;
    rd  = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (port ? me_ready : if_ready) begin
        lat = c;
        rd  = port ? me_rdata : if_rdata;
        break;
      end
      next_cycle();
      if (c == 0) begin
        me_addr  = me_addr ^ 32'h0000_0004;
        if_addr  = if_addr ^ 32'h0000_0004;
        me_wdata = ~me_wdata;
        me_we    = ~me_we;
      end
    end
    next_cycle();
    if_req = 1'b0;
    me_req = 1'b0;
    me_we  = 1'b0;
  endtask

  vec_t vecs [13];

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        exp_me_rdy, exp_if_rdy;

    // Hand-computed transactions, applied in order from IDLE.
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_1000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h55AA_55AA, 32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'h55AA_55AA, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h55AA_55AA, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h55AA_55AA, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'h0BAD_F00D, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 32'h55AA_55AA, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h55AA_55AA, 1'b1};

    resetn   = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    me_req   = 1'b0;
    me_we    = 1'b0;
    me_addr  = '0;
    me_wdata = '0;

    // ---- Reset state ----
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst if_ready", 32'(if_ready), 32'd0);
    check("rst me_ready", 32'(me_ready), 32'd0);
    check("rst if_rdata", if_rdata, 32'd0);
    check("rst me_rdata", me_rdata, 32'd0);
    check("rst misalign", 32'(misalign), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    resetn = 1'b1;
    next_cycle();

    // ---- Table of single transactions ----
    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(LATENCY + 1));
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d misalign", i), 32'(misalign), 32'(vecs[i].exp_mis));
    end

    // ---- Simultaneous requests: me first, then if via DONE hand-over ----
    me_addr = 32'h0000_0010;
    if_addr = 32'h0000_0000;
    me_we   = 1'b0;
    for (int c = 0; c < 8; c++) begin
      me_req = (c <= 3);
      if_req = (c <= 6);
      exp_me_rdy = (c == 3);
      exp_if_rdy = (c == 6);
      @(negedge clock);
      check($sformatf("sim c%0d me_ready", c), 32'(me_ready), 32'(exp_me_rdy));
      check($sformatf("sim c%0d if_ready", c), 32'(if_ready), 32'(exp_if_rdy));
      check($sformatf("sim c%0d stall", c), 32'(stall),
            32'((if_req & ~exp_if_rdy) | (me_req & ~exp_me_rdy)));
      next_cycle();
    end
    if_req = 1'b0;
    me_req = 1'b0;
    check("sim me_rdata", me_rdata, 32'h55AA_55AA);
    check("sim if_rdata", if_rdata, 32'hCAFE_F00D);

    // ---- Continuous contention: grants alternate me, if, me, if, me ----
    for (int c = 0; c < 17; c++) begin
      me_req = (c <= 12);
      if_req = (c <= 12);
      @(negedge clock);
      check($sformatf("rr c%0d me_ready", c), 32'(me_ready),
            32'(c == 3 || c == 9 || c == 15));
      check($sformatf("rr c%0d if_ready", c), 32'(if_ready),
            32'(c == 6 || c == 12));
      next_cycle();
    end
    if_req = 1'b0;
    me_req = 1'b0;

    // ---- Dropped request: me pulses only while if is busy ----
    if_addr = 32'h0000_0FFC;
    for (int c = 0; c < 7; c++) begin
      if_req = (c <= 3);
      me_req = (c == 1);
      @(negedge clock);
      check($sformatf("drop c%0d me_ready", c), 32'(me_ready), 32'd0);
      check($sformatf("drop c%0d if_ready", c), 32'(if_ready), 32'(c == 3));
      next_cycle();
    end
    if_req = 1'b0;
    me_req = 1'b0;
    check("drop if_rdata", if_rdata, 32'h0BAD_F00D);
    run_txn(1'b1, 1'b0, 32'h0000_0000, 32'h0, lat, rd);
    check("drop next latency", 32'(lat), 32'(LATENCY + 1));
    check("drop next rdata", rd, 32'hCAFE_F00D);

    // ---- Reset during an access ----
    run_txn(1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111, lat, rd);
    run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, rd);
    check("pre-rst load", rd, 32'h1111_1111);
    me_req   = 1'b1;
    me_we    = 1'b1;
    me_addr  = 32'h0000_0020;
    me_wdata = 32'h1234_5678;
    next_cycle();                 // cycle 1: BUSY, cnt = 1
    next_cycle();                 // cycle 2: BUSY, cnt = 0 (write edge ahead)
    resetn = 1'b0;
    me_req = 1'b0;
    me_we  = 1'b0;
    @(negedge clock);
    check("midrst me_ready", 32'(me_ready), 32'd0);
    check("midrst if_ready", 32'(if_ready), 32'd0);
    check("midrst me_rdata", me_rdata, 32'd0);
    check("midrst if_rdata", if_rdata, 32'd0);
    check("midrst misalign", 32'(misalign), 32'd0);
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    next_cycle();
    run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, rd);
    check("post-rst latency", 32'(lat), 32'(LATENCY + 1));
    check("post-rst @0x20", rd, 32'h1111_1111);
    check("post-rst misalign", 32'(misalign), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule : tb_mem_responder
